process_scheduler: RTL and testbench
====================================

Name: process_scheduler

Overview:
- Consumer of the quantum counter's context-switch signals: saves the interrupted PC, selects the next process round-robin, and drives the PC to load.
- Holds a table of NUM_PROCS slots, each with a PC and a state. Handles process creation, termination, I/O blocking and I/O completion.
- Sits between the quantum counter and the PC register of the LabSO processor.

Parameters:
NUM_PROCS, 4, number of process slots (power of two)
PID_W, 2, width of a process id, log2(NUM_PROCS)
PC_W, 32, width of a program counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
troca_contexto  input  1  one-cycle pulse: quantum expired, current process goes back to READY
instrucao_io  input  1  one-cycle pulse: current process issued I/O, goes to BLOCKED
fim_processo  input  1  one-cycle pulse: current process finished, slot goes to FREE
pc_salvo  input  PC_W  PC to store for the current process; valid with any event pulse
io_done  input  1  one-cycle pulse: I/O finished for io_done_pid
io_done_pid  input  PID_W  slot whose I/O finished
create_valid  input  1  one-cycle pulse: create a process starting at create_pc
create_pc  input  PC_W  start PC of the new process
pc_novo  output  PC_W  PC of the dispatched process; valid while pc_load=1
pc_load  output  1  one-cycle pulse: processor loads pc_novo
pid_atual  output  PID_W  slot currently or last running
running  output  1  a process is loaded on the CPU
busy  output  1  FSM is not in IDLE
ocioso  output  1  no READY or RUNNING process exists
create_ack  output  1  one-cycle pulse: creation accepted
tabela_cheia  output  1  no FREE slot exists (combinational from the table)
evento_perdido  output  1  sticky: an event pulse arrived while busy; cleared only by reset

Behaviour:
- Slot states: FREE=0, READY=1, RUNNING=2, BLOCKED=3.
- Reset (asynchronous):
  - every slot FREE, every PC 0, FSM in IDLE;
  - all outputs 0 except ocioso=1;
  - pid_atual=0.
- FSM states: IDLE, SAVE, SELECT, LOAD.
- IDLE, evaluated every cycle with priority fim_processo > instrucao_io > troca_contexto > create_valid > auto-dispatch:
  - Event pulse while running=1: latch pc_salvo and the event type, go to SAVE. Event pulses while running=0 are ignored.
  - create_valid with no event:
    - the lowest-index FREE slot gets PC=create_pc and state READY;
    - create_ack=1 on the next cycle;
    - if tabela_cheia=1, the request is dropped and create_ack stays 0;
    - FSM stays in IDLE.
  - Auto-dispatch: running=0, any slot READY, and no event or create this cycle: go to SELECT.
- SAVE (one cycle):
  - table[pid_atual].pc gets the latched PC;
  - state becomes FREE (fim), BLOCKED (io) or READY (quantum);
  - running=0; go to SELECT.
- SELECT (one cycle):
  - Search from (pid_atual+1) mod NUM_PROCS, wrapping; pid_atual itself is checked last. A lone READY process therefore re-dispatches itself after a quantum expiry.
  - If found: register the chosen pid and go to LOAD.
  - If not found: ocioso=1, running=0, go to IDLE, no pc_load pulse.
- LOAD (one cycle):
  - pc_load=1, pc_novo=table[pid].pc;
  - pid_atual=pid, slot becomes RUNNING, running=1, ocioso=0;
  - go to IDLE.
- Latency:
  - event pulse at cycle T gives pc_load at T+3; busy=1 during T+1..T+3;
  - auto-dispatch decided at T gives pc_load at T+2.
- Event pulses (troca_contexto, instrucao_io, fim_processo) arriving while busy=1 are dropped and set evento_perdido. create_valid while busy=1 is dropped silently.
- io_done is processed in any FSM state:
  - if slot io_done_pid is BLOCKED it becomes READY the next cycle;
  - for any other slot state it is ignored;
  - if SAVE blocks the same slot in the same cycle, SAVE wins and io_done is ignored (the slot was RUNNING when sampled).
- io_done in the same cycle as SELECT: the slot's READY state is visible from the next cycle, not to this SELECT.
- PC values are stored and returned unmodified; the block does no PC arithmetic.
- pc_novo holds its last value outside pc_load.
- Reset asserted mid-switch: FSM returns to IDLE immediately, the table is cleared and no pc_load is issued.

Test Plan:
- Reset, create at PCs 0x100 and 0x200, wait -> create_ack on two cycles; auto pc_load with pc_novo=0x100, pid_atual=0, running=1.
- troca_contexto with pc_salvo=0x10A -> pc_load exactly 3 cycles later with pc_novo=0x200, pid 1; slot 0 READY, PC 0x10A; next quantum returns pc_novo=0x10A.
- Single process, instrucao_io with pc_salvo=0x155 -> no pc_load, ocioso=1, running=0; io_done pid 0 -> READY, then pc_load pc_novo=0x155 two cycles after dispatch decision.
- fim_processo on each of 4 running processes -> slots FREE in turn, tabela_cheia 0, final ocioso=1; a fifth create after 4 creates with a full table -> create_ack=0.
- troca_contexto pulsed again during busy -> evento_perdido=1 and sticky; only one pc_load issued.
- Assert reset during SELECT -> no pc_load, all outputs at reset values, ocioso=1, all slots FREE.

Source files
------------

// File: rtl/process_scheduler.sv
// process_scheduler: round-robin process table for the LabSO processor.
// Accepts the quantum counter's context-switch events, saves the interrupted
// PC, picks the next READY slot and issues a one-cycle PC load.
module process_scheduler #(
  parameter int unsigned NUM_PROCS = 4,
  parameter int unsigned PID_W     = 2,
  parameter int unsigned PC_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             troca_contexto,
  input  logic             instrucao_io,
  input  logic             fim_processo,
  input  logic [PC_W-1:0]  pc_salvo,
  input  logic             io_done,
  input  logic [PID_W-1:0] io_done_pid,
  input  logic             create_valid,
  input  logic [PC_W-1:0]  create_pc,
  output logic [PC_W-1:0]  pc_novo,
  output logic             pc_load,
  output logic [PID_W-1:0] pid_atual,
  output logic             running,
  output logic             busy,
  output logic             ocioso,
  output logic             create_ack,
  output logic             tabela_cheia,
  output logic             evento_perdido
);

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_READY   = 2'd1,
    SLOT_RUNNING = 2'd2,
    SLOT_BLOCKED = 2'd3
  } slot_t;

  typedef enum logic [1:0] {IDLE, SAVE, SELECT, LOAD} fsm_t;

  typedef enum logic [1:0] {EV_QUANTUM, EV_IO, EV_FIM} ev_t;

  slot_t            slot_state [NUM_PROCS];
  logic [PC_W-1:0]  slot_pc    [NUM_PROCS];

  fsm_t             state, state_nx;
  ev_t              ev_kind;
  logic [PC_W-1:0]  ev_pc;
  logic [PID_W-1:0] sel_pid;
  logic             has_run;

  logic             any_event;
  logic             take_event;
  logic             take_create;
  logic             auto_dispatch;
  logic             any_ready;
  logic             any_active;
  logic             free_found;
  logic [PID_W-1:0] free_idx;
  logic [PID_W-1:0] search_start;
  logic             found;
  logic [PID_W-1:0] found_idx;

  // Table summaries: lowest FREE slot, any READY, any READY/RUNNING.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    any_ready  = 1'b0;
    any_active = 1'b0;
    for (int unsigned i = 0; i < NUM_PROCS; i++) begin
      if (!free_found && slot_state[i] == SLOT_FREE) begin
        free_found = 1'b1;
        free_idx   = PID_W'(i);
      end
      if (slot_state[i] == SLOT_READY) begin
        any_ready = 1'b1;
      end
      if (slot_state[i] == SLOT_READY || slot_state[i] == SLOT_RUNNING) begin
        any_active = 1'b1;
      end
    end
    tabela_cheia = !free_found;
    ocioso       = !any_active;
  end

  // Round-robin search: starts after the last running slot, which is checked last.
  // Until something has been dispatched there is no "last" slot, so the search
  // starts at slot 0 and the first created process runs first.
  always_comb begin
    search_start = has_run ? PID_W'(pid_atual + 1'b1) : '0;
    found        = 1'b0;
    found_idx    = '0;
    for (int unsigned i = 0; i < NUM_PROCS; i++) begin
      if (!found && slot_state[PID_W'(search_start + i)] == SLOT_READY) begin
        found     = 1'b1;
        found_idx = PID_W'(search_start + i);
      end
    end
  end

  // IDLE arbitration: events (only while running) > create > auto-dispatch.
  always_comb begin
    any_event     = troca_contexto | instrucao_io | fim_processo;
    take_event    = (state == IDLE) && running && any_event;
    take_create   = (state == IDLE) && !(running && any_event) && create_valid && free_found;
    auto_dispatch = (state == IDLE) && !running && !any_event && !create_valid && any_ready;
  end

  // FSM next state and decoded outputs.
  always_comb begin
    state_nx = state;
    pc_load  = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (take_event) begin
          state_nx = SAVE;
        end else if (auto_dispatch) begin
          state_nx = SELECT;
        end
      end
      SAVE:   state_nx = SELECT;
      SELECT: state_nx = found ? LOAD : IDLE;
      LOAD: begin
        pc_load  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Process table; later assignments win, so SAVE overrides a same-slot io_done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PROCS; i++) begin
        slot_state[i] <= SLOT_FREE;
        slot_pc[i]    <= '0;
      end
    end else begin
      if (io_done && slot_state[io_done_pid] == SLOT_BLOCKED) begin
        slot_state[io_done_pid] <= SLOT_READY;
      end
      if (take_create) begin
        slot_state[free_idx] <= SLOT_READY;
        slot_pc[free_idx]    <= create_pc;
      end
      if (state == SAVE) begin
        slot_pc[pid_atual] <= ev_pc;
        unique case (ev_kind)
          EV_FIM:  slot_state[pid_atual] <= SLOT_FREE;
          EV_IO:   slot_state[pid_atual] <= SLOT_BLOCKED;
          default: slot_state[pid_atual] <= SLOT_READY;
        endcase
      end
      if (state == LOAD) begin
        slot_state[sel_pid] <= SLOT_RUNNING;
      end
    end
  end

  // Event latch, dispatch registers and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ev_kind        <= EV_QUANTUM;
      ev_pc          <= '0;
      sel_pid        <= '0;
      pc_novo        <= '0;
      pid_atual      <= '0;
      running        <= 1'b0;
      has_run        <= 1'b0;
      create_ack     <= 1'b0;
      evento_perdido <= 1'b0;
    end else begin
      create_ack <= take_create;
      if (take_event) begin
        ev_pc <= pc_salvo;
        if (fim_processo) begin
          ev_kind <= EV_FIM;
        end else if (instrucao_io) begin
          ev_kind <= EV_IO;
        end else begin
          ev_kind <= EV_QUANTUM;
        end
      end
      if (state == SAVE) begin
        running <= 1'b0;
      end
      if (state == SELECT && found) begin
        sel_pid <= found_idx;
        pc_novo <= slot_pc[found_idx];
      end
      if (state == LOAD) begin
        pid_atual <= sel_pid;
        running   <= 1'b1;
        has_run   <= 1'b1;
      end
      if (busy && any_event) begin
        evento_perdido <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler with hand-computed expectations.
module tb_process_scheduler;

  logic        clock;
  logic        reset;
  logic        troca_contexto;
  logic        instrucao_io;
  logic        fim_processo;
  logic [31:0] pc_salvo;
  logic        io_done;
  logic [1:0]  io_done_pid;
  logic        create_valid;
  logic [31:0] create_pc;
  logic [31:0] pc_novo;
  logic        pc_load;
  logic [1:0]  pid_atual;
  logic        running;
  logic        busy;
  logic        ocioso;
  logic        create_ack;
  logic        tabela_cheia;
  logic        evento_perdido;

  int passes = 0;
  int checks = 0;

  process_scheduler #(.NUM_PROCS(4), .PID_W(2), .PC_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .troca_contexto (troca_contexto),
    .instrucao_io   (instrucao_io),
    .fim_processo   (fim_processo),
    .pc_salvo       (pc_salvo),
    .io_done        (io_done),
    .io_done_pid    (io_done_pid),
    .create_valid   (create_valid),
    .create_pc      (create_pc),
    .pc_novo        (pc_novo),
    .pc_load        (pc_load),
    .pid_atual      (pid_atual),
    .running        (running),
    .busy           (busy),
    .ocioso         (ocioso),
    .create_ack     (create_ack),
    .tabela_cheia   (tabela_cheia),
    .evento_perdido (evento_perdido)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_load"}, 32'(pc_load), 32'd0);
    check({tag, "_pc_novo"}, pc_novo, 32'd0);
    check({tag, "_pid"}, 32'(pid_atual), 32'd0);
    check({tag, "_running"}, 32'(running), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ocioso"}, 32'(ocioso), 32'd1);
    check({tag, "_ack"}, 32'(create_ack), 32'd0);
    check({tag, "_cheia"}, 32'(tabela_cheia), 32'd0);
    check({tag, "_perdido"}, 32'(evento_perdido), 32'd0);
  endtask

  task automatic create(input logic [31:0] pc, input logic exp_ack, input string tag);
    create_valid = 1'b1;
    create_pc    = pc;
    tick();
    create_valid = 1'b0;
    check({tag, "_ack"}, 32'(create_ack), 32'(exp_ack));
  endtask

  // kind: 0 = troca_contexto, 1 = instrucao_io, 2 = fim_processo
  task automatic run_event(input int kind, input logic [31:0] pc, input logic exp_load,
                           input logic [31:0] exp_pc, input logic [1:0] exp_pid,
                           input string tag);
    troca_contexto = (kind == 0);
    instrucao_io   = (kind == 1);
    fim_processo   = (kind == 2);
    pc_salvo       = pc;
    tick();
    troca_contexto = 1'b0;
    instrucao_io   = 1'b0;
    fim_processo   = 1'b0;
    check({tag, "_busy_save"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_noload_select"}, 32'(pc_load), 32'd0);
    tick();
    if (exp_load) begin
      check({tag, "_pc_load"}, 32'(pc_load), 32'd1);
      check({tag, "_pc_novo"}, pc_novo, exp_pc);
      tick();
      check({tag, "_pid"}, 32'(pid_atual), 32'(exp_pid));
      check({tag, "_running"}, 32'(running), 32'd1);
      check({tag, "_load_end"}, 32'(pc_load), 32'd0);
    end else begin
      check({tag, "_no_pc_load"}, 32'(pc_load), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_running0"}, 32'(running), 32'd0);
      check({tag, "_ocioso"}, 32'(ocioso), 32'd1);
    end
  endtask

  initial begin
    reset          = 1'b1;
    troca_contexto = 1'b0;
    instrucao_io   = 1'b0;
    fim_processo   = 1'b0;
    pc_salvo       = '0;
    io_done        = 1'b0;
    io_done_pid    = '0;
    create_valid   = 1'b0;
    create_pc      = '0;

    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();
    check_reset_outputs("post_reset");

    // Two creates, then auto-dispatch of slot 0 two cycles after the decision.
    create(32'h100, 1'b1, "create0");
    check("create0_ocioso", 32'(ocioso), 32'd0);
    create(32'h200, 1'b1, "create1");
    tick();
    check("auto_ack_clear", 32'(create_ack), 32'd0);
    check("auto_busy", 32'(busy), 32'd1);
    check("auto_noload", 32'(pc_load), 32'd0);
    tick();
    check("auto_pc_load", 32'(pc_load), 32'd1);
    check("auto_pc_novo", pc_novo, 32'h100);
    tick();
    check("auto_pid", 32'(pid_atual), 32'd0);
    check("auto_running", 32'(running), 32'd1);
    check("auto_idle", 32'(busy), 32'd0);
    check("auto_ocioso", 32'(ocioso), 32'd0);

    // Quantum expiry: slot 0 -> READY with 0x10A, slot 1 dispatched.
    run_event(0, 32'h10A, 1'b1, 32'h200, 2'd1, "quantum0");

    // Quantum on slot 1 with a second pulse while busy: lost event, single load.
    troca_contexto = 1'b1;
    pc_salvo       = 32'h20B;
    tick();
    pc_salvo       = 32'h999;
    tick();
    troca_contexto = 1'b0;
    check("lost_flag", 32'(evento_perdido), 32'd1);
    check("lost_noload", 32'(pc_load), 32'd0);
    tick();
    check("lost_pc_load", 32'(pc_load), 32'd1);
    check("resume_pc_novo", pc_novo, 32'h10A);
    tick();
    check("resume_pid", 32'(pid_atual), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_load", 32'(pc_load), 32'd0);
      check("lost_sticky", 32'(evento_perdido), 32'd1);
    end

    // Slot 0 finishes; slot 1 resumes with the PC latched by the first pulse.
    run_event(2, 32'h10C, 1'b1, 32'h20B, 2'd1, "fim0");

    // Lone process blocks on I/O: nothing to run.
    run_event(1, 32'h155, 1'b0, 32'h0, 2'd0, "io_block");
    check("io_block_cheia", 32'(tabela_cheia), 32'd0);
    io_done     = 1'b1;
    io_done_pid = 2'd1;
    tick();
    io_done     = 1'b0;
    check("io_done_ready", 32'(ocioso), 32'd0);
    check("io_done_idle", 32'(busy), 32'd0);
    tick();
    check("io_dispatch_busy", 32'(busy), 32'd1);
    check("io_dispatch_noload", 32'(pc_load), 32'd0);
    tick();
    check("io_pc_load", 32'(pc_load), 32'd1);
    check("io_pc_novo", pc_novo, 32'h155);
    tick();
    check("io_pid", 32'(pid_atual), 32'd1);
    check("io_running", 32'(running), 32'd1);

    // Fill the table around running slot 1, then one create too many.
    create(32'hA00, 1'b1, "fill0");
    create(32'hB00, 1'b1, "fill2");
    check("fill2_not_full", 32'(tabela_cheia), 32'd0);
    create(32'hC00, 1'b1, "fill3");
    check("full", 32'(tabela_cheia), 32'd1);
    create(32'hD00, 1'b0, "overflow");
    check("still_full", 32'(tabela_cheia), 32'd1);

    // Finish every process in turn.
    run_event(2, 32'h0, 1'b1, 32'hB00, 2'd2, "fim1");
    check("fim1_cheia", 32'(tabela_cheia), 32'd0);
    run_event(2, 32'h0, 1'b1, 32'hC00, 2'd3, "fim2");
    run_event(2, 32'h0, 1'b1, 32'hA00, 2'd0, "fim3");
    run_event(2, 32'h0, 1'b0, 32'h0, 2'd0, "fim_last");
    check("all_free_cheia", 32'(tabela_cheia), 32'd0);

    // Reset asserted while the FSM is in SELECT.
    create(32'h300, 1'b1, "pre_reset");
    tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("after_reset_noload", 32'(pc_load), 32'd0);
      check("after_reset_ocioso", 32'(ocioso), 32'd1);
      check("after_reset_idle", 32'(busy), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
